deser_fifo: RTL
===============

Name: deser_fifo

Overview:
- Parametrised successor to the serial-deserializer plus queue pair, merged into one block.
- Serial bits arrive on data_in, qualified by write_in, and are assembled into DATA_W-bit words in configurable bit order.
- Completed words go into a DEPTH-entry circular FIFO that is read with dequeue_in.
- Adds backpressure (status_out), occupancy, full/empty flags and sticky drop detection.

Parameters:
- DATA_W, 8, word width in bits (>=2)
- DEPTH, 4, FIFO entries (>=2, need not be a power of two)
- MSB_FIRST, 1, 1 = first received bit lands in word[DATA_W-1]; 0 = first bit lands in word[0]

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- data_in  in  1  serial data bit
- write_in  in  1  data_in valid this cycle
- dequeue_in  in  1  pop head word this cycle
- data_out  out  DATA_W  head word of the FIFO (first-word fall-through); 0 when empty
- data_valid_out  out  1  FIFO not empty
- len_out  out  $clog2(DEPTH+1)  current occupancy
- full_out  out  1  len_out == DEPTH
- empty_out  out  1  len_out == 0
- status_out  out  1  deserializer ready to accept a bit
- overflow_out  out  1  sticky: a bit was offered while status_out=0

Behaviour:
- Reset: the clock is single; reset is asynchronous and active-high. While reset is asserted, bit counter, shift register, pointers and len are cleared, state=ASSEMBLE, and outputs are status_out=1, data_out=0, data_valid_out=0, len_out=0, empty_out=1, full_out=0, overflow_out=0.
- Deserializer FSM:
  - ASSEMBLE: status_out=1. On each edge with write_in=1, data_in is shifted in and bit_cnt increments. When the DATA_W-th bit is sampled, the word is latched, bit_cnt returns to 0 and the FSM moves to HANDOFF.
  - HANDOFF: status_out=0. A push occurs on any edge where len_out<DEPTH or dequeue_in=1. On a push, the FSM returns to ASSEMBLE. Otherwise it holds HANDOFF, with the word preserved, indefinitely.
- write_in while status_out=0: the bit is dropped and overflow_out sets to 1 and stays set until reset.
- Latency:
  - Last bit sampled at edge N; push at edge N+1 when not blocked.
  - If the FIFO was empty, data_out and data_valid_out update after edge N+1.
  - status_out is low for exactly one cycle when not blocked.
- FIFO:
  - head and tail pointers wrap from DEPTH-1 to 0.
  - Push writes at tail. Pop (dequeue_in=1 and len>0) advances head.
  - Push and pop on the same edge: len unchanged, order preserved, and a push while full is legal in that case.
  - dequeue_in while empty is ignored, with no pointer or len change.
- Full: pushes are blocked and the deserializer stalls in HANDOFF; no data is lost in the FIFO.
- Reset mid-word discards the partial word. The next DATA_W accepted bits form a fresh word.
- All outputs are registered or decoded only from registered state; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: DESER_FIFO_PARITY_EN.
- Defined:
  - Each word is DATA_W data bits followed by one even-parity bit (DATA_W+1 accepted bits).
  - Adds output port parity_err_out (1 bit).
  - A word with bad parity is discarded, not pushed. parity_err_out pulses high for one cycle at the HANDOFF edge, and the FSM returns to ASSEMBLE.
  - The parity bit is not stored.
- Undefined: DATA_W bits per word, no parity_err_out port, every completed word is pushed.

Test Plan:
- MSB_FIRST=1, DATA_W=8: reset, then send bits 1,0,1,0,0,1,0,1 on consecutive cycles -> status_out=0 for one cycle; one cycle after the last bit, data_out=0xA5, len_out=1, data_valid_out=1.
- MSB_FIRST=0: send the same bit sequence -> data_out=0xA5 reversed, i.e. 0xA5 with bit order mirrored = 0xA5 (palindrome). Also send 1,0,0,0,0,0,0,0 -> 0x01 (versus 0x80 with MSB_FIRST=1).
- DEPTH=4: push 0x01..0x04 -> full_out=1, len_out=4. Send 0x05 -> status_out stays 0. Pulse dequeue_in once -> 0x05 pushed on the same edge, len_out=4, data_out=0x02. Drain -> 0x02, 0x03, 0x04, 0x05, then empty_out=1.
- len_out=2 (0x10, 0x11): complete a word 0x12 whose HANDOFF edge coincides with dequeue_in -> len_out=2, data_out=0x11, next pop gives 0x12. dequeue_in with empty FIFO -> len_out stays 0, data_out=0.
- Assert write_in during HANDOFF -> overflow_out=1 and remains 1 across later words until reset; the dropped bit does not appear in the next word.
- Reset asserted after 3 bits of a word -> all outputs at reset values immediately. After release, 8 bits of 0x3C -> data_out=0x3C. With DESER_FIFO_PARITY_EN, 0x3C+parity 1 -> parity_err_out pulse, len_out unchanged.

Source files
------------

// File: rtl/deser_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : deser_fifo                                                 |
// | Description : Serial-to-parallel word assembler feeding a DEPTH-entry    |
// |               first-word-fall-through FIFO with backpressure, sticky     |
// |               drop flag and optional even parity (DESER_FIFO_PARITY_EN). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module deser_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       dequeue_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       data_valid_out,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic                       status_out,
    output logic                       overflow_out
`ifdef DESER_FIFO_PARITY_EN
    ,
    output logic                       parity_err_out
`endif
);

`ifdef DESER_FIFO_PARITY_EN
    localparam int c_NBITS = DATA_W + 1;
`else
    localparam int c_NBITS = DATA_W;
`endif
    localparam int c_CNT_W = $clog2(c_NBITS);
    localparam int c_LEN_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(c_NBITS - 1);
    localparam logic [c_LEN_W-1:0] c_DEPTH_L  = c_LEN_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ASSEMBLE = 1'b0,
        HANDOFF  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [c_PTR_W-1:0]   head_q, head_d;
    logic [c_PTR_W-1:0]   tail_q, tail_d;
    logic [c_LEN_W-1:0]   len_q, len_d;
    logic                 overflow_q, overflow_d;
    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [DATA_W-1:0]    w_shifted;
    logic                 w_push;
    logic                 w_pop;
`ifdef DESER_FIFO_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        head_d     = head_q;
        tail_d     = tail_q;
        len_d      = len_q;
        w_push     = 1'b0;
        w_pop      = dequeue_in && (len_q != '0);
        overflow_d = overflow_q | (write_in & (state_q == HANDOFF));
`ifdef DESER_FIFO_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (MSB_FIRST) begin
            w_shifted = {shift_q[DATA_W-2:0], data_in};
        end else begin
            w_shifted = {data_in, shift_q[DATA_W-1:1]};
        end

        case (state_q)
            ASSEMBLE: begin
                if (write_in) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef DESER_FIFO_PARITY_EN
                    // The trailing parity bit is checked but never stored.
                    if (bit_cnt_q == c_LAST_BIT) begin
                        par_bad_d = (^shift_q) ^ data_in;
                    end else begin
                        shift_d = w_shifted;
                    end
`else
                    shift_d = w_shifted;
`endif
                    if (bit_cnt_q == c_LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = HANDOFF;
                    end
                end
            end
            HANDOFF: begin
`ifdef DESER_FIFO_PARITY_EN
                if (par_bad_q) begin
                    state_d      = ASSEMBLE;
                    parity_err_d = 1'b1;
                end else
`endif
                // A full FIFO still accepts the word if the head leaves this edge.
                if ((len_q != c_DEPTH_L) || dequeue_in) begin
                    w_push  = 1'b1;
                    state_d = ASSEMBLE;
                end
            end
            default: state_d = ASSEMBLE;
        endcase

        if (w_push) begin
            tail_d = (tail_q == c_LAST_PTR) ? '0 : tail_q + 1'b1;
        end
        if (w_pop) begin
            head_d = (head_q == c_LAST_PTR) ? '0 : head_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   len_d = len_q + 1'b1;
            2'b01:   len_d = len_q - 1'b1;
            default: len_d = len_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ASSEMBLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
`ifdef DESER_FIFO_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
`ifdef DESER_FIFO_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Storage needs no reset: every read is gated by the occupancy count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[tail_q] <= shift_q;
        end
    end

    assign status_out     = (state_q == ASSEMBLE);
    assign data_valid_out = (len_q != '0);
    assign empty_out      = (len_q == '0);
    assign full_out       = (len_q == c_DEPTH_L);
    assign len_out        = len_q;
    assign overflow_out   = overflow_q;
    assign data_out       = (len_q == '0) ? '0 : mem_q[head_q];
`ifdef DESER_FIFO_PARITY_EN
    assign parity_err_out = parity_err_q;
`endif

endmodule
`default_nettype wire
